// File: rtl/bus_timer_responder.sv
// Memory-mapped tick timer on the shared 8-bit processor bus, with one level interrupt.
// Registers: +0 TICKS, +1 INTERVAL, +2 CTRL {IRQ_EN,RUN}, +3 STATUS {RAISE,RUN}.
module bus_timer_responder #(
  parameter logic [7:0]  BASE_ADDR        = 8'hF0,
  parameter int unsigned CLK_PER_TICK     = 50000,
  parameter logic [7:0]  DEFAULT_INTERVAL = 8'd100
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam int unsigned PRE_W    = 16;
  localparam int unsigned DATA_W   = 8;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_TICK - 1);

  logic [PRE_W-1:0]  pre_q,      pre_d;
  logic [DATA_W-1:0] ticks_q,    ticks_d;
  logic [DATA_W-1:0] interval_q, interval_d;
  logic [1:0]        ctrl_q,     ctrl_d;
  logic              raise_q,    raise_d;
  logic [DATA_W-1:0] rd_data_q,  rd_data_d;
  logic              drive_en_q, drive_en_d;

  logic       hit, wr_en, rd_en, status_wr;
  logic [1:0] off;
  logic       tick, match, timer_event;

  // Address decode for the four-register window.
  assign hit       = (BUS_ADDR[7:2] == BASE_ADDR[7:2]);
  assign off       = BUS_ADDR[1:0];
  assign wr_en     = hit & BUS_WE;
  assign rd_en     = hit & ~BUS_WE;
  assign status_wr = wr_en & (off == 2'd3);

  // Tick and interval match use the pre-edge RUN/INTERVAL, so a same-cycle write never masks a tick.
  assign tick        = ctrl_q[0] & (pre_q == PRE_LAST);
  assign match       = (interval_q != 8'd0) & (ticks_q == (interval_q - 8'd1));
  assign timer_event = tick & match;

  assign BUS_DATA            = drive_en_q ? rd_data_q : {DATA_W{1'bz}};
  assign BUS_INTERRUPT_RAISE = raise_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pre_q      <= '0;
      ticks_q    <= '0;
      interval_q <= DEFAULT_INTERVAL;
      ctrl_q     <= 2'b11;
      raise_q    <= 1'b0;
      rd_data_q  <= '0;
      drive_en_q <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      ticks_q    <= ticks_d;
      interval_q <= interval_d;
      ctrl_q     <= ctrl_d;
      raise_q    <= raise_d;
      rd_data_q  <= rd_data_d;
      drive_en_q <= drive_en_d;
    end
  end

  always_comb begin
    pre_d      = pre_q;
    ticks_d    = ticks_q;
    interval_d = interval_q;
    ctrl_d     = ctrl_q;
    raise_d    = raise_q;
    rd_data_d  = rd_data_q;
    drive_en_d = rd_en;

    if (ctrl_q[0]) begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end
    if (tick) begin
      ticks_d = match ? '0 : ticks_q + 8'd1;
    end

    // A new request takes priority over a simultaneous acknowledge.
    if (timer_event && ctrl_q[1]) begin
      raise_d = 1'b1;
    end else if (BUS_INTERRUPT_ACK) begin
      raise_d = 1'b0;
    end

    if (wr_en) begin
      case (off)
        2'd1:    interval_d = BUS_DATA;
        2'd2:    ctrl_d     = BUS_DATA[1:0];
        default: ;
      endcase
    end

    // STATUS write overrides any counting or interrupt update this cycle.
    if (status_wr) begin
      pre_d   = '0;
      ticks_d = '0;
      raise_d = 1'b0;
    end

    if (rd_en) begin
      case (off)
        2'd0:    rd_data_d = ticks_q;
        2'd1:    rd_data_d = interval_q;
        2'd2:    rd_data_d = {6'b0, ctrl_q};
        default: rd_data_d = {6'b0, raise_q, ctrl_q[0]};
      endcase
    end
  end

endmodule
